serial_subtractor: RTL

//  Bit-serial unsigned subtractor: computes Diff = A - B - Bin, one bit per clock, LSB first.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding used by the top and by anything that
// observes its state (IDLE=0, SHIFT=1, DONE=2).
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow comes in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B - Bin, one bit per clock,
// LSB first, using a single full-subtractor cell and a borrow flop.
//
// Handshake: start is accepted on a rising edge where start=1 and ready=1
// (ready is high only in IDLE). Operands are copied on that edge, so A/B/Bin
// may change afterwards. busy is high for WIDTH cycles, then done pulses for
// exactly one cycle with Diff/Bout valid; start seen outside IDLE is ignored.
//
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous active-high reset
//   start in  1      operation request
//   A     in  WIDTH  minuend
//   B     in  WIDTH  subtrahend
//   Bin   in  1      borrow in
//   ready out 1      idle, able to accept start
//   busy  out 1      shifting
//   done  out 1      one-cycle result pulse
//   Diff  out WIDTH  registered result (A - B - Bin) mod 2^WIDTH
//   Bout  out 1      registered final borrow (A < B + Bin)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             fs_d, fs_bout;
  logic             last_bit;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (state == ST_SHIFT) && (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state and status outputs
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_n = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath: operand/result shift registers, counter, borrow and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      Diff <= '0;
      Bout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr <= A;
            b_sr <= B;
            br   <= Bin;
            cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= fs_bout;
          // Difference bits enter at the MSB so after WIDTH shifts the
          // first (LSB) bit has reached position 0.
          d_sr <= {fs_d, d_sr[WIDTH-1:1]};
          if (last_bit) begin
            Diff <= {fs_d, d_sr[WIDTH-1:1]};
            Bout <= fs_bout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
